// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode stage.
// Optional build macro used by decode_stage: DECODE_PERF_EN (pop/illegal counters).
package decode_pkg;

   typedef enum logic [3:0] {
      T_NONE    = 4'b0000,
      T_LOAD    = 4'b0001,
      T_STORE   = 4'b0010,
      T_RALU    = 4'b0011,
      T_IALU    = 4'b0100,
      T_BRANCH  = 4'b0101,
      T_JAL     = 4'b0110,
      T_JALR    = 4'b0111,
      T_LUI     = 4'b1000,
      T_AUIPC   = 4'b1001,
      T_FENCE   = 4'b1010,
      T_SYSTEM  = 4'b1011,
      T_ILLEGAL = 4'b1111
   } inst_type_e;

   typedef enum logic [2:0] {
      IMM_I   = 3'b000,
      IMM_S   = 3'b001,
      IMM_R   = 3'b010,
      IMM_B   = 3'b011,
      IMM_J   = 3'b100,
      IMM_U   = 3'b101,
      IMM_INV = 3'b111
   } imm_type_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RALU   = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // Decoded bundle. The immediate is kept sign-extended to 32 bits (every
   // RV32I immediate fits); the stage widens it to XLEN. The pc travels
   // beside the bundle because its width is a stage parameter.
   typedef struct packed {
      inst_type_e  inst_type;
      imm_type_e   imm_type;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  func3;
      logic [6:0]  func7;
      logic [31:0] imm;
      logic        illegal;
   } decoded_t;

   localparam decoded_t DEC_RST = '{
      inst_type: T_NONE, imm_type: IMM_INV, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
      func3: 3'd0, func7: 7'd0, imm: 32'd0, illegal: 1'b0};

endpackage

// File: rtl/rv32i_decode_comb.sv
// Purely combinational RV32I decoder: raw instruction to decoded bundle.
module rv32i_decode_comb
   import decode_pkg::*;
(
   input  logic [31:0] instr,
   output decoded_t    dec
);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
   logic        ill;

   assign opc   = instr[6:0];
   assign f3    = instr[14:12];
   assign f7    = instr[31:25];
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};

   // Field extraction per format, then collapse to the illegal bundle
   always_comb begin
      dec          = DEC_RST;
      dec.imm_type = IMM_R;
      ill          = 1'b0;
      case (opc)
         OP_LOAD: begin
            dec.inst_type = T_LOAD;   dec.imm_type = IMM_I;
            dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.func3 = f3; dec.imm = imm_i;
            ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OP_STORE: begin
            dec.inst_type = T_STORE;  dec.imm_type = IMM_S;
            dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20]; dec.func3 = f3; dec.imm = imm_s;
            ill = (f3 > 3'b010);
         end
         OP_RALU: begin
            dec.inst_type = T_RALU;   dec.imm_type = IMM_R;
            dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20];
            dec.func3 = f3; dec.func7 = f7;
            ill = !((f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         OP_IALU: begin
            dec.inst_type = T_IALU;   dec.imm_type = IMM_I;
            dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.func3 = f3; dec.imm = imm_i;
            if (f3 == 3'b001) begin
               dec.func7 = f7;
               ill = (f7 != 7'b0000000);
            end else if (f3 == 3'b101) begin
               dec.func7 = f7;
               ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
         end
         OP_BRANCH: begin
            dec.inst_type = T_BRANCH; dec.imm_type = IMM_B;
            dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20]; dec.func3 = f3; dec.imm = imm_b;
            ill = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OP_JAL: begin
            dec.inst_type = T_JAL;    dec.imm_type = IMM_J;
            dec.rd = instr[11:7]; dec.imm = imm_j;
         end
         OP_JALR: begin
            dec.inst_type = T_JALR;   dec.imm_type = IMM_I;
            dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.func3 = f3; dec.imm = imm_i;
            ill = (f3 != 3'b000);
         end
         OP_LUI: begin
            dec.inst_type = T_LUI;    dec.imm_type = IMM_U;
            dec.rd = instr[11:7]; dec.imm = imm_u;
         end
         OP_AUIPC: begin
            dec.inst_type = T_AUIPC;  dec.imm_type = IMM_U;
            dec.rd = instr[11:7]; dec.imm = imm_u;
         end
         OP_FENCE: begin
            dec.inst_type = T_FENCE;  dec.imm_type = IMM_I;
            dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.func3 = f3; dec.imm = imm_i;
         end
         OP_SYSTEM: begin
            dec.inst_type = T_SYSTEM; dec.imm_type = IMM_I;
            dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.func3 = f3; dec.imm = imm_i;
         end
         default: ill = 1'b1;
      endcase
      if (instr[1:0] != 2'b11) ill = 1'b1;
      if (ill) begin
         dec           = '0;
         dec.inst_type = T_ILLEGAL;
         dec.imm_type  = IMM_INV;
         dec.illegal   = 1'b1;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a main entry plus a skid entry so fetch
// can stream one instruction per cycle under backpressure.
// Optional build macro: DECODE_PERF_EN adds perf_decoded / perf_illegal.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = XLEN
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [3:0]      out_inst_type,
   output logic [2:0]      out_imm_type,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [2:0]      out_func3,
   output logic [6:0]      out_func7,
   output logic [XLEN-1:0] out_imm,
`ifdef DECODE_PERF_EN
   output logic [31:0]     perf_decoded,
   output logic [31:0]     perf_illegal,
`endif
   output logic            out_illegal
);

   decoded_t        dec, main_q, skid_q;
   logic [PC_W-1:0] main_pc, skid_pc;
   logic            main_v, skid_v;
   logic            accept, pop;

   rv32i_decode_comb u_dec (.instr(in_instr), .dec(dec));

   // The skid entry is only ever filled while main is stalled, so a full skid
   // is exactly the condition for refusing new input.
   assign in_ready = !skid_v && !rst;
   assign accept   = in_valid && in_ready && !flush;
   assign pop      = main_v && out_ready;

   // Main/skid storage; skid drains into main before new input is taken
   always_ff @(posedge clk) begin
      if (rst) begin
         main_v  <= 1'b0;
         skid_v  <= 1'b0;
         main_q  <= DEC_RST;
         skid_q  <= DEC_RST;
         main_pc <= '0;
         skid_pc <= '0;
      end else if (flush) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
      end else if (skid_v) begin
         if (pop) begin
            main_q  <= skid_q;
            main_pc <= skid_pc;
            skid_v  <= 1'b0;
         end
      end else if (accept) begin
         if (!main_v || pop) begin
            main_q  <= dec;
            main_pc <= in_pc;
            main_v  <= 1'b1;
         end else begin
            skid_q  <= dec;
            skid_pc <= in_pc;
            skid_v  <= 1'b1;
         end
      end else if (pop) begin
         main_v <= 1'b0;
      end
   end

   assign out_valid     = main_v;
   assign out_pc        = main_pc;
   assign out_inst_type = main_q.inst_type;
   assign out_imm_type  = main_q.imm_type;
   assign out_rd        = main_q.rd;
   assign out_rs1       = main_q.rs1;
   assign out_rs2       = main_q.rs2;
   assign out_func3     = main_q.func3;
   assign out_func7     = main_q.func7;
   assign out_illegal   = main_q.illegal;

   generate
      if (XLEN == 32) begin : g_imm32
         assign out_imm = main_q.imm;
      end else begin : g_immw
         assign out_imm = {{(XLEN-32){main_q.imm[31]}}, main_q.imm};
      end
   endgenerate

`ifdef DECODE_PERF_EN
   // Saturating pop counters; flush does not touch them
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_decoded <= '0;
         perf_illegal <= '0;
      end else if (pop) begin
         if (perf_decoded != '1) perf_decoded <= perf_decoded + 32'd1;
         if (main_q.illegal && (perf_illegal != '1)) perf_illegal <= perf_illegal + 32'd1;
      end
   end
`endif

endmodule
